// File: rtl/cache_fetch_engine_pkg.sv
// Shared types and constants for the cache line fetch / write-back engine.
package cache_fetch_engine_pkg;

    // Default cache line length in words.
    localparam int unsigned LineWordsDefault = 4;

    // FSM state encoding, kept as plain constants for compatibility with older tools.
    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t StIdle      = 3'd0;
    localparam fetch_state_t StWbRd      = 3'd1;
    localparam fetch_state_t StWbWr      = 3'd2;
    localparam fetch_state_t StFillReq   = 3'd3;
    localparam fetch_state_t StFillDrain = 3'd4;
    localparam fetch_state_t StDone      = 3'd5;

    // Width of a word index within a line.
    function automatic int unsigned idx_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Width of a line address given the memory depth and line length.
    function automatic int unsigned laddr_width(input int unsigned mem_depth,
                                                input int unsigned line_words);
        return $clog2(mem_depth) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/cache_fetch_engine.sv
// Line refill / write-back initiator. On a miss it optionally writes the dirty
// victim line back word by word, then reads the missing line with pipelined
// requests and streams the returned words into the cache data array.
module cache_fetch_engine
    import cache_fetch_engine_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = LineWordsDefault,
    localparam int unsigned AW  = $clog2(MEM_DEPTH),
    localparam int unsigned IW  = idx_width(LINE_WORDS),
    localparam int unsigned LAW = laddr_width(MEM_DEPTH, LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LAW-1:0]        req_fill_laddr,
    input  logic                  req_wb,
    input  logic [LAW-1:0]        req_wb_laddr,
    output logic                  done,
    output logic                  wb_rd_en,
    output logic [IW-1:0]         wb_rd_idx,
    input  logic [DATA_WIDTH-1:0] wb_rd_data,
    output logic                  fill_wen,
    output logic [IW-1:0]         fill_idx,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic [AW-1:0]         fetch_mem_raddr,
    output logic                  fetch_mem_ren,
    input  logic                  fetch_mem_rready,
    input  logic [DATA_WIDTH-1:0] fetch_mem_rdata,
    input  logic                  fetch_mem_rdata_valid,
    output logic [AW-1:0]         fetch_mem_waddr,
    output logic                  fetch_mem_wen,
    input  logic                  fetch_mem_wready,
    output logic [DATA_WIDTH-1:0] fetch_mem_wdata
);

    localparam logic [IW-1:0] LastIdx = IW'(LINE_WORDS - 1);

    fetch_state_t          state_q, state_d;
    logic [LAW-1:0]        fill_laddr_q, fill_laddr_d;
    logic [LAW-1:0]        wb_laddr_q, wb_laddr_d;
    logic [IW-1:0]         wb_idx_q, wb_idx_d;
    logic [IW-1:0]         iss_cnt_q, iss_cnt_d;
    logic [IW-1:0]         rcv_cnt_q, rcv_cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    // High in the first WB_WR cycle, when the array read data is live on wb_rd_data.
    logic                  wr_first_q, wr_first_d;
    logic                  in_fill;

    assign in_fill = (state_q == StFillReq) || (state_q == StFillDrain);

    // Next-state logic for the FSM, counters and latched addresses.
    always_comb begin
        state_d      = state_q;
        fill_laddr_d = fill_laddr_q;
        wb_laddr_d   = wb_laddr_q;
        wb_idx_d     = wb_idx_q;
        iss_cnt_d    = iss_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        wdata_d      = wr_first_q ? wb_rd_data : wdata_q;
        wr_first_d   = (state_q == StWbRd);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    fill_laddr_d = req_fill_laddr;
                    wb_laddr_d   = req_wb_laddr;
                    wb_idx_d     = '0;
                    iss_cnt_d    = '0;
                    rcv_cnt_d    = '0;
                    state_d      = req_wb ? StWbRd : StFillReq;
                end
            end
            StWbRd: begin
                state_d = StWbWr;
            end
            StWbWr: begin
                if (fetch_mem_wready) begin
                    if (wb_idx_q == LastIdx) begin
                        state_d = StFillReq;
                    end else begin
                        wb_idx_d = wb_idx_q + 1'b1;
                        state_d  = StWbRd;
                    end
                end
            end
            StFillReq: begin
                if (fetch_mem_rready) begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                    if (iss_cnt_q == LastIdx) begin
                        state_d = StFillDrain;
                    end
                end
            end
            StFillDrain: begin
                state_d = StFillDrain;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Returned words are counted in both fill states; the last one ends the refill.
        if (in_fill && fetch_mem_rdata_valid) begin
            rcv_cnt_d = rcv_cnt_q + 1'b1;
            if (rcv_cnt_q == LastIdx) begin
                state_d = StDone;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fill_laddr_q <= '0;
            wb_laddr_q   <= '0;
            wb_idx_q     <= '0;
            iss_cnt_q    <= '0;
            rcv_cnt_q    <= '0;
            wdata_q      <= '0;
            wr_first_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_laddr_q <= fill_laddr_d;
            wb_laddr_q   <= wb_laddr_d;
            wb_idx_q     <= wb_idx_d;
            iss_cnt_q    <= iss_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            wdata_q      <= wdata_d;
            wr_first_q   <= wr_first_d;
        end
    end

    // Output decode from the current state and counters.
    always_comb begin
        req_ready       = (state_q == StIdle);
        done            = (state_q == StDone);
        wb_rd_en        = (state_q == StWbRd);
        wb_rd_idx       = wb_idx_q;
        fill_wen        = in_fill && fetch_mem_rdata_valid;
        fill_idx        = rcv_cnt_q;
        fill_data       = in_fill ? fetch_mem_rdata : '0;
        fetch_mem_ren   = (state_q == StFillReq);
        fetch_mem_raddr = {fill_laddr_q, iss_cnt_q};
        fetch_mem_wen   = (state_q == StWbWr);
        fetch_mem_waddr = {wb_laddr_q, wb_idx_q};
        // Bypass the capture register on the first write cycle so each word takes 2 cycles.
        fetch_mem_wdata = wr_first_q ? wb_rd_data : wdata_q;
    end

endmodule
